// File: rtl/osc_mon_pkg.sv
// Shared types and default constants for the oscillator frequency monitor.
package osc_mon_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StMeasure
    } mon_state_e;

    localparam int unsigned DefGateCycles  = 50000;
    localparam int unsigned DefCntWidth    = 16;
    localparam int unsigned DefSyncStages  = 2;
    localparam int unsigned DefStuckCycles = 1024;

endpackage

// File: rtl/osc_mon_sync.sv
// Multi-flop synchronizer for an asynchronous oscillator input followed by a rising-edge detector.
module osc_mon_sync
    import osc_mon_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DefSyncStages
) (
    input  logic clk,
    input  logic reset,
    input  logic osc_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], osc_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/osc_freq_monitor.sv
// Counts oscillator rising edges over a fixed gate window and flags out-of-range counts.
// Optional no-edge timeout enabled by defining OSC_MON_STUCK_DETECT_EN.
module osc_freq_monitor
    import osc_mon_pkg::*;
#(
    parameter int unsigned GATE_CYCLES  = DefGateCycles,
    parameter int unsigned CNT_WIDTH    = DefCntWidth,
    parameter int unsigned SYNC_STAGES  = DefSyncStages,
    parameter int unsigned STUCK_CYCLES = DefStuckCycles
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 osc_in,
    input  logic [CNT_WIDTH-1:0] min_count,
    input  logic [CNT_WIDTH-1:0] max_count,
    input  logic                 fault_clr,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 count_valid,
    output logic                 fault,
    output logic                 stuck
);

    localparam int unsigned GW = $clog2(GATE_CYCLES);
    localparam int unsigned AW = $clog2(SYNC_STAGES + 1);
    localparam logic [GW-1:0] GateLast = GW'(GATE_CYCLES - 1);
    localparam logic [AW-1:0] ArmLast  = AW'(SYNC_STAGES);

    mon_state_e           state_q, state_d;
    logic [AW-1:0]        arm_q, arm_d;
    logic [GW-1:0]        gate_q, gate_d;
    logic [CNT_WIDTH-1:0] edge_q, edge_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 valid_q, valid_d;
    logic                 fault_q, fault_d;
    logic [CNT_WIDTH-1:0] edge_inc;
    logic                 close;
    logic                 rise;

    osc_mon_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .reset  (reset),
        .osc_in (osc_in),
        .rise   (rise)
    );

    // Saturating increment; includes a pulse landing in the closing cycle.
    assign edge_inc = (rise && (edge_q != '1)) ? edge_q + 1'b1 : edge_q;

    always_comb begin
        state_d = state_q;
        arm_d   = arm_q;
        gate_d  = gate_q;
        edge_d  = edge_q;
        count_d = count_q;
        valid_d = 1'b0;
        close   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (en) begin
                    state_d = StArm;
                    arm_d   = '0;
                end
            end
            StArm: begin
                if (!en) begin
                    state_d = StIdle;
                end else if (arm_q == ArmLast) begin
                    state_d = StMeasure;
                    gate_d  = '0;
                    edge_d  = '0;
                end else begin
                    arm_d = arm_q + 1'b1;
                end
            end
            StMeasure: begin
                if (!en) begin
                    state_d = StIdle;
                end else if (gate_q == GateLast) begin
                    close   = 1'b1;
                    gate_d  = '0;
                    edge_d  = '0;
                    count_d = edge_inc;
                    valid_d = 1'b1;
                end else begin
                    gate_d = gate_q + 1'b1;
                    edge_d = edge_inc;
                end
            end
            default: state_d = StIdle;
        endcase

        fault_d = fault_q & ~fault_clr;
        if (close && ((edge_inc < min_count) || (edge_inc > max_count))) begin
            fault_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            arm_q   <= '0;
            gate_q  <= '0;
            edge_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            arm_q   <= arm_d;
            gate_q  <= gate_d;
            edge_q  <= edge_d;
            count_q <= count_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    assign count       = count_q;
    assign count_valid = valid_q;
    assign fault       = fault_q;

`ifdef OSC_MON_STUCK_DETECT_EN
    localparam int unsigned SW = $clog2(STUCK_CYCLES + 1);
    localparam logic [SW-1:0] StuckLast = SW'(STUCK_CYCLES - 1);

    logic [SW-1:0] stuck_cnt_q, stuck_cnt_d;
    logic          stuck_q, stuck_d;
    logic          stuck_set;

    // Timeout restarts after firing so a persistent stall keeps re-asserting after a clear.
    always_comb begin
        stuck_cnt_d = '0;
        stuck_set   = 1'b0;
        if (state_q == StMeasure && en && !rise) begin
            if (stuck_cnt_q == StuckLast) begin
                stuck_set = 1'b1;
            end else begin
                stuck_cnt_d = stuck_cnt_q + 1'b1;
            end
        end
        stuck_d = stuck_set | (stuck_q & ~fault_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stuck_cnt_q <= '0;
            stuck_q     <= 1'b0;
        end else begin
            stuck_cnt_q <= stuck_cnt_d;
            stuck_q     <= stuck_d;
        end
    end

    assign stuck = stuck_q;
`else
    assign stuck = 1'b0;
`endif

endmodule

// File: tb/tb_osc_freq_monitor.sv
// Directed self-checking bench for osc_freq_monitor with hand-computed window counts and latencies.
module tb_osc_freq_monitor;

    logic        clk = 1'b0;
    logic        reset, en, osc, fault_clr;
    logic [15:0] min_c, max_c, count;
    logic        valid, fault, stuck;

    logic        en_s, osc_s;
    logic [3:0]  min_s, max_s, count_s;
    logic        valid_s, fault_s, stuck_s;

    int half   = 10;
    int half_s = 2;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    osc_freq_monitor #(
        .GATE_CYCLES (1000),
        .CNT_WIDTH   (16),
        .SYNC_STAGES (2),
        .STUCK_CYCLES(100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .osc_in     (osc),
        .min_count  (min_c),
        .max_count  (max_c),
        .fault_clr  (fault_clr),
        .count      (count),
        .count_valid(valid),
        .fault      (fault),
        .stuck      (stuck)
    );

    osc_freq_monitor #(
        .GATE_CYCLES(1000),
        .CNT_WIDTH  (4)
    ) dut_sat (
        .clk        (clk),
        .reset      (reset),
        .en         (en_s),
        .osc_in     (osc_s),
        .min_count  (min_s),
        .max_count  (max_s),
        .fault_clr  (fault_clr),
        .count      (count_s),
        .count_valid(valid_s),
        .fault      (fault_s),
        .stuck      (stuck_s)
    );

    // Oscillators toggle every `half` clocks, offset from the clock edge; half==0 holds low.
    initial begin
        osc = 1'b0;
        forever begin
            if (half == 0) begin
                osc = 1'b0;
                @(posedge clk);
            end else begin
                repeat (half) @(posedge clk);
                #2 osc = ~osc;
            end
        end
    end

    initial begin
        osc_s = 1'b0;
        forever begin
            repeat (half_s) @(posedge clk);
            #2 osc_s = ~osc_s;
        end
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Counts negedges (one per posedge) until count_valid is seen.
    task automatic wait_valid(input int limit, output int n);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (valid) return;
            if (n >= limit) begin
                check("valid_timeout", 0, 1);
                return;
            end
        end
    endtask

    task automatic pulse_clr();
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
    endtask

    initial begin
        int n;
        int seen;
        reset     = 1'b1;
        en        = 1'b0;
        en_s      = 1'b0;
        fault_clr = 1'b0;
        min_c     = 16'd45;
        max_c     = 16'd55;
        min_s     = 4'd0;
        max_s     = 4'd14;
        repeat (3) @(negedge clk);
        check("rst_count", count, 0);
        check("rst_valid", valid, 0);
        check("rst_fault", fault, 0);
        check("rst_stuck", stuck, 0);
        check("rst_count_sat", count_s, 0);

        // Nominal 20-clock period: 50 edges per 1000-cycle window.
        reset = 1'b0;
        en    = 1'b1;
        en_s  = 1'b1;
        wait_valid(3000, n);
        check("first_latency", n, 1004);
        check("first_count_pm1", (count >= 49 && count <= 51), 1);
        check("first_fault", fault, 0);
        wait_valid(1100, n);
        check("window_period", n, 1000);
        check("nominal_count", count, 50);
        check("nominal_fault", fault, 0);
        @(negedge clk);
        check("valid_one_cycle", valid, 0);

        // Slow oscillator: 40-clock period gives 25 edges, below the 45 floor.
        en   = 1'b0;
        half = 20;
        repeat (50) @(negedge clk);
        en = 1'b1;
        wait_valid(3000, n);
        check("slow_latency", n, 1004);
        check("slow_count_pm1", (count >= 24 && count <= 26), 1);
        check("slow_fault_set", fault, 1);
        pulse_clr();
        check("fault_cleared", fault, 0);
        wait_valid(1100, n);
        check("slow_count", count, 25);
        check("slow_fault_reset", fault, 1);

        // Clear asserted in the closing cycle: the set wins.
        pulse_clr();
        check("fault_cleared2", fault, 0);
        repeat (998) @(negedge clk);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        check("simul_valid", valid, 1);
        check("simul_fault", fault, 1);

        // Inverted limits fault every window.
        pulse_clr();
        min_c = 16'd30;
        max_c = 16'd20;
        wait_valid(1100, n);
        check("inv_limits_fault", fault, 1);

        // Abort mid-window: no strobe, count and fault hold.
        min_c = 16'd20;
        max_c = 16'd30;
        pulse_clr();
        repeat (499) @(negedge clk);
        en   = 1'b0;
        seen = 0;
        repeat (1500) begin
            @(negedge clk);
            if (valid) seen++;
        end
        check("abort_no_valid", seen, 0);
        check("abort_count_hold", count, 25);
        check("abort_fault_hold", fault, 0);
        en = 1'b1;
        wait_valid(3000, n);
        check("reenable_latency", n, 1004);
        check("reenable_count_pm1", (count >= 24 && count <= 26), 1);

        // 4-bit counter, 250 edges per window: saturates at 15.
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid_s && n < 1100);
        check("sat_valid_seen", valid_s, 1);
        check("sat_count", count_s, 15);
        check("sat_fault", fault_s, 1);

        // Oscillator held low.
        en   = 1'b0;
        half = 0;
        pulse_clr();
        repeat (40) @(negedge clk);
        check("pre_stuck_clear", stuck, 0);
        en   = 1'b1;
        n    = 0;
        seen = 0;
`ifdef OSC_MON_STUCK_DETECT_EN
        do begin
            @(negedge clk);
            n++;
            if (valid) seen++;
        end while (!stuck && n < 300);
        check("stuck_latency", n, 104);
        check("stuck_before_valid", seen, 0);
        pulse_clr();
        check("stuck_cleared", stuck, 0);
`else
        repeat (1200) begin
            @(negedge clk);
            if (stuck) seen++;
        end
        check("stuck_tied_low", seen, 0);
        check("zero_edges_count", count, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/osc_freq_monitor.md
# osc_freq_monitor

Fabric-side frequency checker for the on-chip oscillator outputs (RC 25/50 MHz, RC 1 MHz, crystal) after they are routed to the fabric. It counts rising edges of one asynchronous oscillator signal over a fixed gate window of system clocks. Each window produces a count, a one-cycle valid strobe and a sticky out-of-range fault. It sits between the oscillator block's O2F output and the APB status registers.

## Interface
- GATE_CYCLES, 50000: window length in CLK cycles (≥ 4); 1 ms at 50 MHz.
- CNT_WIDTH, 16: width of edge counter, limits and COUNT.
- SYNC_STAGES, 2: synchronizer flops on OSC_IN (≥ 2).
- STUCK_CYCLES, 1024: no-edge timeout, used only with OSC_MON_STUCK_DETECT_EN.

- CLK  in  1  system clock; single clock domain.
- RESET  in  1  synchronous, active-high reset.
- EN  in  1  measurement enable.
- OSC_IN  in  1  oscillator output, asynchronous to CLK.
- MIN_COUNT  in  CNT_WIDTH  lowest legal edges per window.
- MAX_COUNT  in  CNT_WIDTH  highest legal edges per window.
- FAULT_CLR  in  1  clears FAULT (and STUCK).
- COUNT  out  CNT_WIDTH  edges in the last completed window.
- COUNT_VALID  out  1  one-cycle strobe when COUNT updates.
- FAULT  out  1  sticky range fault.
- STUCK  out  1  sticky no-edge fault; present only with OSC_MON_STUCK_DETECT_EN, otherwise tied 0.

## Operation
- Reset values: COUNT=0, COUNT_VALID=0, FAULT=0, STUCK=0; state IDLE; all synchronizer flops 0.
- OSC_IN passes through SYNC_STAGES flops, then one edge-detect flop. A rising edge is registered as a one-cycle pulse.
- States:
  - IDLE: wait for EN=1, then go to ARM.
  - ARM: SYNC_STAGES+1 cycles; edge pulses are ignored to flush stale history; then go to MEASURE.
  - MEASURE: gate counter runs 0..GATE_CYCLES-1. The edge counter increments on each pulse.
- Edge counter saturates at 2^CNT_WIDTH-1 and never wraps.
- Last gate cycle (including any pulse in that cycle): COUNT ← final edge count and COUNT_VALID=1 on the next cycle. The edge counter and gate counter restart at 0 in that same cycle. Windows are contiguous, with no dead cycle.
- Range check at window close: count < MIN_COUNT or count > MAX_COUNT sets FAULT in the same cycle COUNT_VALID asserts. The compare is unsigned.
- If MIN_COUNT > MAX_COUNT, every window faults.
- FAULT clears only on FAULT_CLR. If a set and FAULT_CLR occur in the same cycle, the set wins.
- EN=0 in ARM or MEASURE: abort next cycle to IDLE. No COUNT_VALID; COUNT and FAULT hold.
- EN re-asserted: a fresh ARM follows and the partial window is discarded.
- RESET mid-window: all state returns to reset values next cycle.

## Timing
- OSC_IN edge to internal pulse: SYNC_STAGES+1 cycles.
- EN rise to first counted cycle: 1 (IDLE→ARM) + SYNC_STAGES+1 cycles.
- Window period is exactly GATE_CYCLES cycles. COUNT_VALID recurs every GATE_CYCLES cycles while EN=1.
- Measurable OSC_IN frequency is below CLK/2. Higher frequencies undercount and are not flagged except via MIN_COUNT.
- Limits are sampled in the cycle of the range compare only.

## Configuration
- OSC_MON_STUCK_DETECT_EN defined:
  - A timeout counter runs in MEASURE and resets on every edge pulse.
  - Reaching STUCK_CYCLES sets STUCK immediately, without waiting for the window to close.
  - STUCK clears with FAULT_CLR; a set wins over a simultaneous clear.
- Undefined: no timeout counter; STUCK is constant 0.

## Structure
- Shared package osc_mon_pkg holds the state enum (IDLE, ARM, MEASURE) and default constants for GATE_CYCLES, SYNC_STAGES and STUCK_CYCLES.
- Sub-module osc_mon_sync holds the SYNC_STAGES synchronizer plus the edge-detect flop, and outputs a rise pulse.
- Top level holds the FSM, counters, compare logic and sticky flags.

## Test plan
- Reset behaviour: GATE_CYCLES=1000, OSC_IN period 20 CLK, limits 45..55, EN=1 → COUNT_VALID every 1000 cycles with COUNT=50 (±1 on the first window); FAULT=0.
- Low frequency: same setup, OSC_IN period 40 CLK → COUNT=25, FAULT=1 on the first COUNT_VALID. Then FAULT_CLR pulse in a non-closing cycle → FAULT=0, and it re-sets at the next window.
- Saturation: CNT_WIDTH=4, OSC_IN period 4 CLK, GATE_CYCLES=1000 → COUNT=15 (saturated, no wrap), FAULT=1 with MAX_COUNT=14.
- Abort: EN drops at gate cycle 500 → no COUNT_VALID, COUNT keeps its previous value. Re-enable → first COUNT_VALID exactly 1+SYNC_STAGES+1+1000 cycles later.
- Simultaneous set and clear: FAULT_CLR asserted in the range-fault cycle → FAULT=1.
- Stuck detect (OSC_MON_STUCK_DETECT_EN, STUCK_CYCLES=100): hold OSC_IN=0 → STUCK=1 at cycle 100 of MEASURE, before any COUNT_VALID. Without the macro, STUCK stays 0.
